// File: rtl/imm_gen_stage.sv
// Decode-stage immediate generator.
// Builds the sign- or zero-extended XLEN-bit immediate for one instruction per
// cycle and registers it together with the instruction and PC. A skid entry
// sits behind the output register, so a registered in_ready still sustains one
// transfer per cycle while downstream is ready.
//
// Handshake: a transfer happens on any rising edge where valid and ready are
// both high. in_ready comes straight from a flop and never depends on
// out_ready. out_* hold steady while out_valid && !out_ready.
module imm_gen_stage #(
  parameter int XLEN        = 32,
  parameter bit AUTO_DECODE = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [2:0]      in_imm_type,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [2:0]      out_type,
  output logic            out_illegal
);

  localparam logic [2:0] T_I     = 3'b000;
  localparam logic [2:0] T_S     = 3'b001;
  localparam logic [2:0] T_B     = 3'b010;
  localparam logic [2:0] T_U     = 3'b011;
  localparam logic [2:0] T_J     = 3'b100;
  localparam logic [2:0] T_SHAMT = 3'b101;
  localparam logic [2:0] T_ZIMM  = 3'b110;
  localparam logic [2:0] T_NONE  = 3'b111;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [2:0]      auto_type;
  logic [2:0]      dec_type;
  logic [XLEN-1:0] dec_imm;
  logic            dec_illegal;
  logic [5:0]      shamt_f;
  logic            sgn;

  // Skid entry, filled only when the output is stalled while an input lands.
  logic            skid_valid;
  logic [XLEN-1:0] skid_imm;
  logic [31:0]     skid_instr;
  logic [XLEN-1:0] skid_pc;
  logic [2:0]      skid_type;
  logic            skid_illegal;

  logic accept;
  logic out_xfer;
  logic out_free;

  assign opcode   = in_instr[6:0];
  assign funct3   = in_instr[14:12];
  assign sgn      = in_instr[31];
  // RV64 shift amounts use one more bit than RV32 ones.
  assign shamt_f  = (XLEN == 64) ? in_instr[25:20] : {1'b0, in_instr[24:20]};

  assign in_ready = ~skid_valid;
  assign accept   = in_valid & in_ready & ~flush;
  assign out_xfer = out_valid & out_ready;
  assign out_free = ~out_valid | out_xfer;

  // Derive the immediate type from the opcode map (used when AUTO_DECODE=1).
  always_comb begin
    auto_type = T_NONE;
    case (opcode)
      7'b0010011: auto_type = (funct3 == 3'b001 || funct3 == 3'b101) ? T_SHAMT : T_I;
      7'b0000011,
      7'b1100111,
      7'b0011011: auto_type = T_I;
      7'b0100011: auto_type = T_S;
      7'b1100011: auto_type = T_B;
      7'b0110111,
      7'b0010111: auto_type = T_U;
      7'b1101111: auto_type = T_J;
      7'b1110011: auto_type = funct3[2] ? T_ZIMM : T_I;
      default:    auto_type = T_NONE;
    endcase
  end

  assign dec_type    = AUTO_DECODE ? auto_type : in_imm_type;
  assign dec_illegal = (dec_type == T_NONE);

  // Single type mux producing the extended immediate.
  always_comb begin
    dec_imm = '0;
    case (dec_type)
      T_I:     dec_imm = {{(XLEN-11){sgn}}, in_instr[30:20]};
      T_S:     dec_imm = {{(XLEN-11){sgn}}, in_instr[30:25], in_instr[11:7]};
      T_B:     dec_imm = {{(XLEN-12){sgn}}, in_instr[7], in_instr[30:25],
                          in_instr[11:8], 1'b0};
      T_U:     dec_imm = {{(XLEN-31){sgn}}, in_instr[30:12], 12'b0};
      T_J:     dec_imm = {{(XLEN-20){sgn}}, in_instr[19:12], in_instr[20],
                          in_instr[30:21], 1'b0};
      T_SHAMT: dec_imm = {{(XLEN-6){1'b0}}, shamt_f};
      T_ZIMM:  dec_imm = {{(XLEN-5){1'b0}}, in_instr[19:15]};
      default: dec_imm = '0;
    endcase
  end

  // Output register and skid entry: load, drain, stall and flush handling.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_imm      <= '0;
      out_instr    <= '0;
      out_pc       <= '0;
      out_type     <= T_NONE;
      out_illegal  <= 1'b0;
      skid_valid   <= 1'b0;
      skid_imm     <= '0;
      skid_instr   <= '0;
      skid_pc      <= '0;
      skid_type    <= T_NONE;
      skid_illegal <= 1'b0;
    end else if (flush) begin
      // A downstream transfer in this cycle still completes; everything held is dropped.
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (skid_valid) begin
      // in_ready is low here, so the only event is the skid draining forward.
      if (out_xfer) begin
        out_valid   <= 1'b1;
        out_imm     <= skid_imm;
        out_instr   <= skid_instr;
        out_pc      <= skid_pc;
        out_type    <= skid_type;
        out_illegal <= skid_illegal;
        skid_valid  <= 1'b0;
      end
    end else if (accept) begin
      if (out_free) begin
        out_valid   <= 1'b1;
        out_imm     <= dec_imm;
        out_instr   <= in_instr;
        out_pc      <= in_pc;
        out_type    <= dec_type;
        out_illegal <= dec_illegal;
      end else begin
        skid_valid   <= 1'b1;
        skid_imm     <= dec_imm;
        skid_instr   <= in_instr;
        skid_pc      <= in_pc;
        skid_type    <= dec_type;
        skid_illegal <= dec_illegal;
      end
    end else if (out_xfer) begin
      out_valid <= 1'b0;
    end
  end

endmodule
